ro_pair_counter: RTL and testbench
==================================

Name: ro_pair_counter

Overview:
- Measurement front end of the RO PUF. Enables one selected ring-oscillator pair, counts rising edges of each oscillator over a fixed clock-cycle window, and presents the two 16-bit counts for the downstream count comparator, which turns them into one response bit.
- Sequenced by the challenge/response controller through a start/done handshake.

Parameters:
- CNT_W, 16, width of each edge counter and count output.
- SETTLE_CYCLES, 16, clock cycles the oscillators run before counting starts; must be ≥1.
- WINDOW_CYCLES, 4096, length of the counting window in clock cycles; must be ≥1.
- SYNC_STAGES, 2, flip-flop synchronizer depth on each oscillator input; must be ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a measurement; accepted only in IDLE.
- ro_a  in  1  oscillator A output; asynchronous, pre-divided to below clk/4.
- ro_b  in  1  oscillator B output; same constraints as ro_a.
- ro_en  out  1  enable to both oscillators of the selected pair.
- busy  out  1  high from start acceptance until and including the done cycle.
- done  out  1  one-cycle pulse; counts valid.
- count_1  out  CNT_W ([0:CNT_W-1], bit 0 = MSB)  edge count of ro_a.
- count_2  out  CNT_W ([0:CNT_W-1], bit 0 = MSB)  edge count of ro_b.

Behaviour:
- Reset (synchronous, any state): state=IDLE; ro_en=0, busy=0, done=0, count_1=count_2=0; synchronizer and edge-detect flops cleared.
- Reset mid-measurement: the measurement is abandoned, with no done pulse.
- FSM states are IDLE, SETTLE, COUNT, DONE.
  - IDLE: when start=1 at edge k, go to SETTLE at k+1. Both counters clear at k+1.
  - SETTLE: ro_en=1, busy=1. Lasts exactly SETTLE_CYCLES cycles, then goes to COUNT.
  - COUNT: ro_en=1, busy=1, count gate=1. Lasts exactly WINDOW_CYCLES cycles, then goes to DONE.
  - DONE: ro_en=0, busy=1, done=1 for exactly one cycle, then returns to IDLE.
- Latency: start accepted at edge k gives done=1 in cycle k+1+SETTLE_CYCLES+WINDOW_CYCLES.
- Edge counting:
  - Each ro input passes through a SYNC_STAGES synchronizer, then a one-flop edge detect. A rising edge is sync_out=1 while the previous value was 0.
  - An edge increments its counter only when the count gate is high on that cycle.
  - The window is therefore defined in the synchronized domain. Edges still in the synchronizer when COUNT ends are not counted.
- Arithmetic: unsigned, saturating. At all-ones the counter holds; there is no wrap-around.
- Output validity:
  - count_1/count_2 are undefined while busy=1, except in the DONE cycle.
  - Once done is asserted, the counts hold until the next accepted start or reset.
- start while busy=1 is ignored, with no queuing. start held high continuously launches back-to-back measurements, with one IDLE cycle between them.
- Simultaneous edges on ro_a and ro_b are counted independently in the same cycle.

Optional Feature:
- Macro RO_OVF_FLAG_EN.
- Defined: adds output port ovf (1 bit), reset 0, cleared on start acceptance. It is set sticky when either counter attempts to increment past all-ones, is valid with done, and holds with the counts.
- Undefined: no ovf port. Saturation behaviour is unchanged.

Decomposition:
- Package ro_puf_pkg holds:
  - the FSM state enum (IDLE, SETTLE, COUNT, DONE);
  - the default CNT_W constant shared with the comparator;
  - the default window constant.
- Sub-module ro_edge_counter contains the synchronizer, edge detect and saturating counter, with parameters CNT_W and SYNC_STAGES and inputs clk, rst, clr, gate, ro.
- ro_edge_counter is instantiated twice. The top holds the FSM and the window/settle counter.

Test Plan (SETTLE_CYCLES=4, WINDOW_CYCLES=64, SYNC_STAGES=2; ro driven clock-aligned unless stated):
- Basic measurement: start pulse at cycle 0; ro_a period 8 clk, ro_b period 16 clk → done exactly at cycle 69; count_1=8, count_2=4; ro_en high over cycles 1..68; busy high over cycles 1..69.
- Saturation: CNT_W=4, ro_a toggling every clk/4 (16 edges in window) → count_1=15. With RO_OVF_FLAG_EN defined, ovf=1; with it undefined, no ovf port exists.
- Start while busy: extra start pulses at cycles 10 and 40 → exactly one done, at cycle 69. Counts are not cleared mid-window.
- Reset mid-operation: rst at cycle 30 → next cycle ro_en=0, busy=0, counts=0, state IDLE. No done pulse follows. A new start gives a normal result.
- Back-to-back and hold: start held high → done at cycles 69 and 139. Counts hold their first-run values through the IDLE cycle at 70, then clear at 71.
- Asynchronous jitter: ro_a period 8.3 clk with random phase over 50 runs → count_1 is 7 or 8 in every run, with no X on any output.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared definitions for the RO PUF measurement path: FSM state encoding,
// default count width and window length, and timer sizing helper.
package ro_puf_pkg;

  localparam int RO_CNT_W         = 16;
  localparam int RO_WINDOW_CYCLES = 4096;
  localparam int RO_SETTLE_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } ro_state_e;

  // Width of a down-counter that must hold the larger of the two reload values (N-1).
  function automatic int ro_tmr_w(input int settle, input int window);
    int m;
    m = (settle > window) ? settle : window;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// One oscillator channel: multi-flop synchronizer, rising-edge detect and a
// saturating edge counter. Optional RO_OVF_FLAG_EN exposes a saturation-hit pulse.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W       = RO_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             gate,
  input  logic             ro,
  output logic [CNT_W-1:0] count
`ifdef RO_OVF_FLAG_EN
  ,
  output logic             ovf_hit
`endif
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;
  logic                   at_max;
  logic                   inc_req;

  // ro is asynchronous; only sync_q[0] may go metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign at_max  = &count;
  assign inc_req = gate & rise;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc_req && !at_max) begin
      count <= count + CNT_W'(1);
    end
  end

`ifdef RO_OVF_FLAG_EN
  assign ovf_hit = inc_req & at_max;
`endif

endmodule

// File: rtl/ro_pair_counter.sv
// RO PUF measurement front end: settles an RO pair, counts both oscillators'
// edges over a fixed window, reports counts with a done pulse. RO_OVF_FLAG_EN adds ovf.
module ro_pair_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W         = RO_CNT_W,
  parameter int SETTLE_CYCLES = RO_SETTLE_CYCLES,
  parameter int WINDOW_CYCLES = RO_WINDOW_CYCLES,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [0:CNT_W-1] count_1,
  output logic [0:CNT_W-1] count_2
`ifdef RO_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int TMR_W = ro_tmr_w(SETTLE_CYCLES, WINDOW_CYCLES);

  // Handshake: start is sampled only while idle (busy=0); a sampled start
  // raises busy next cycle, done pulses for one cycle with busy still high,
  // and the counts stay valid from done until the next accepted start.
  ro_state_e        state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tmr_zero;
  logic             accept;
  logic             gate;
  logic             ro_en_q;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  assign tmr_zero = (tmr_q == '0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SETTLE;
          tmr_d   = TMR_W'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_d = COUNT;
          tmr_d   = TMR_W'(WINDOW_CYCLES - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      COUNT: begin
        if (tmr_zero) begin
          state_d = DONE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ro_en is registered so the oscillator enable never sees decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      ro_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ro_en_q <= (state_d == SETTLE) || (state_d == COUNT);
    end
  end

  assign gate  = (state_q == COUNT);
  assign ro_en = ro_en_q;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);

`ifdef RO_OVF_FLAG_EN
  logic hit_a, hit_b;
  logic ovf_q;
`endif

  ro_edge_counter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cnt_a (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .gate    (gate),
    .ro      (ro_a),
    .count   (cnt_a)
`ifdef RO_OVF_FLAG_EN
    ,
    .ovf_hit (hit_a)
`endif
  );

  ro_edge_counter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cnt_b (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .gate    (gate),
    .ro      (ro_b),
    .count   (cnt_b)
`ifdef RO_OVF_FLAG_EN
    ,
    .ovf_hit (hit_b)
`endif
  );

  assign count_1 = cnt_a;
  assign count_2 = cnt_b;

`ifdef RO_OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      ovf_q <= 1'b0;
    end else if (hit_a || hit_b) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ro_pair_counter.sv
// Scoreboard bench for ro_pair_counter: a 16-bit and a 4-bit (saturating)
// instance share stimulus; expected counts come from the recorded ro waveforms.
`timescale 1ns/1ps
module tb_ro_pair_counter;

  localparam int S    = 4;
  localparam int W    = 64;
  localparam int SY   = 2;
  localparam int CW   = 16;
  localparam int CWS  = 4;
  localparam int HMAX = 16384;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  // ---------------- oscillator sources ----------------
  logic ro_a, ro_b;
  logic ro_a_w = 1'b0, ro_b_w = 1'b0, ro_a_j = 1'b0;
  logic jit_on = 1'b0;
  assign ro_a = jit_on ? ro_a_j : ro_a_w;
  assign ro_b = ro_b_w;

  int          per_a = 8, per_b = 16;
  int unsigned tick = 0;
  int          pers[7] = '{0, 4, 6, 8, 10, 12, 16};

  function automatic logic wave_bit(input int per, input int unsigned t);
    if (per == 0) return logic'($urandom_range(0, 1));
    return ((t % per) < (per / 2));
  endfunction

  always @(posedge clk) begin
    #1;
    tick   = tick + 1;
    ro_a_w = wave_bit(per_a, tick);
    ro_b_w = wave_bit(per_b, tick);
  end

  // ---------------- DUTs ----------------
  logic            ro_en, busy, done;
  logic [0:CW-1]   count_1, count_2;
  logic            s_ro_en, s_busy, s_done;
  logic [0:CWS-1]  s_count_1, s_count_2;
`ifdef RO_OVF_FLAG_EN
  logic ovf, s_ovf;
`endif

  ro_pair_counter #(.CNT_W(CW), .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .SYNC_STAGES(SY)) dut (
    .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en), .busy(busy), .done(done), .count_1(count_1), .count_2(count_2)
`ifdef RO_OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );

  ro_pair_counter #(.CNT_W(CWS), .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .SYNC_STAGES(SY)) dut_s (
    .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(s_ro_en), .busy(s_busy), .done(s_done), .count_1(s_count_1), .count_2(s_count_2)
`ifdef RO_OVF_FLAG_EN
    , .ovf(s_ovf)
`endif
  );

  // ---------------- sampled history (edge-indexed) ----------------
  int unsigned ecnt = 0;
  logic hist_a[HMAX];
  logic hist_b[HMAX];
  logic hist_st[HMAX];
  logic hist_rst[HMAX];

  always @(posedge clk) begin
    if (ecnt < HMAX) begin
      hist_a[ecnt]   <= ro_a;
      hist_b[ecnt]   <= ro_b;
      hist_st[ecnt]  <= start;
      hist_rst[ecnt] <= rst;
    end
    ecnt <= ecnt + 1;
  end

  // Rising transitions of a sampled ro that land inside the synchronized window.
  function automatic int rises(input int s, input bit sel);
    int  c;
    logic cur, prv;
    c = 0;
    for (int j = s + S - SY + 1; j <= s + S + W - SY; j++) begin
      cur = sel ? hist_b[j]     : hist_a[j];
      prv = sel ? hist_b[j - 1] : hist_a[j - 1];
      if (cur === 1'b1 && prv === 1'b0) c++;
    end
    return c;
  endfunction

  function automatic int sat(input int m, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (m > mx) ? mx : m;
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int   tests = 0, fails = 0, n_done = 0, free_edge = 0;
  int   held_a = 0, held_b = 0, held_sa = 0, held_sb = 0;
  logic held_ovf = 1'b0, held_sovf = 1'b0;
  logic sat_mode = 1'b0, jit_mode = 1'b0, end_req = 1'b0, end_ack = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int e);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", nm, e, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    int   e, s, ma, mb;
    logic xb, xe, xd;
    e = int'(ecnt) - 1;
    if (e >= 0 && e < HMAX) begin
      if (hist_rst[e]) begin
        exp_q.delete();
        free_edge = e + 1;
        held_a = 0; held_b = 0; held_sa = 0; held_sb = 0;
        held_ovf = 1'b0; held_sovf = 1'b0;
      end else if (hist_st[e] && e >= free_edge) begin
        exp_q.push_back(32'(e));
        free_edge = e + S + W + 2;
      end
      xb = 1'b0; xe = 1'b0; xd = 1'b0; s = 0;
      if (exp_q.size() > 0) begin
        s  = int'(exp_q[0]);
        xb = 1'b1;
        xe = (e < s + S + W);
        xd = (e == s + S + W);
      end
      chk("busy",   32'(busy),    32'(xb), e);
      chk("ro_en",  32'(ro_en),   32'(xe), e);
      chk("done",   32'(done),    32'(xd), e);
      chk("s_busy", 32'(s_busy),  32'(xb), e);
      chk("s_ro_en",32'(s_ro_en), 32'(xe), e);
      chk("s_done", 32'(s_done),  32'(xd), e);
      chk("no_x", 32'($isunknown({ro_en, busy, done, count_1, count_2, s_count_1, s_count_2})), 32'(0), e);
      if (xd) begin
        ma = rises(s, 1'b0);
        mb = rises(s, 1'b1);
        held_a = ma; held_b = mb;
        held_sa = sat(ma, CWS); held_sb = sat(mb, CWS);
        held_ovf  = (ma > (1 << CW) - 1) || (mb > (1 << CW) - 1);
        held_sovf = (ma > (1 << CWS) - 1) || (mb > (1 << CWS) - 1);
        void'(exp_q.pop_front());
        n_done++;
        if (n_done == 1) begin
          chk("basic_count_1", {16'b0, count_1}, 32'd8, e);
          chk("basic_count_2", {16'b0, count_2}, 32'd4, e);
        end
        if (sat_mode) begin
          chk("sat_count_1", {28'b0, s_count_1}, 32'd15, e);
`ifdef RO_OVF_FLAG_EN
          chk("sat_ovf", 32'(s_ovf), 32'd1, e);
`endif
        end
        if (jit_mode) chk("jitter_range", 32'(count_1 == 16'd7 || count_1 == 16'd8), 32'd1, e);
      end
      if (exp_q.size() == 0 || xd) begin
        chk("count_1",   {16'b0, count_1},   32'(held_a),  e);
        chk("count_2",   {16'b0, count_2},   32'(held_b),  e);
        chk("s_count_1", {28'b0, s_count_1}, 32'(held_sa), e);
        chk("s_count_2", {28'b0, s_count_2}, 32'(held_sb), e);
`ifdef RO_OVF_FLAG_EN
        chk("ovf",   32'(ovf),   32'(held_ovf),  e);
        chk("s_ovf", 32'(s_ovf), 32'(held_sovf), e);
`endif
      end
    end
    if (end_req && !end_ack) begin
      end_ack = 1'b1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0, e);
      chk("history_fits", 32'(e < HMAX), 32'd1, e);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(2);

    // basic measurement
    per_a = 8; per_b = 16;
    pulse_start();
    step(S + W + 4);

    // start pulses while busy are ignored
    pulse_start();
    step(9);
    pulse_start();
    step(29);
    pulse_start();
    step(40);

    // reset mid-measurement, then a normal run
    per_a = 6; per_b = 10;
    pulse_start();
    step(29);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(5);
    pulse_start();
    step(S + W + 4);

    // back-to-back with start held high
    per_a = 8; per_b = 12;
    start = 1'b1;
    step(140);
    start = 1'b0;
    step(S + W + 6);

    // saturation of the 4-bit instance
    sat_mode = 1'b1;
    per_a = 4; per_b = 2;
    for (int r = 0; r < 2; r++) begin
      pulse_start();
      step(S + W + 4);
    end
    sat_mode = 1'b0;

    // randomized periods, gaps and stray starts
    for (int r = 0; r < 12; r++) begin
      per_a = pers[$urandom_range(0, 6)];
      per_b = pers[$urandom_range(0, 6)];
      step($urandom_range(0, 5));
      pulse_start();
      if ($urandom_range(0, 1) == 1) begin
        step($urandom_range(1, 60));
        pulse_start();
      end
      step(S + W + 4);
    end

    // asynchronous ro_a, period 8.3 clk, random phase
    jit_on = 1'b1;
    jit_mode = 1'b1;
    per_b = 10;
    step(2);
    for (int r = 0; r < 50; r++) begin
      real ph;
      ph = real'($urandom_range(0, 82)) + 0.25;
      fork
        begin
          #(ph);
          repeat (26) begin
            ro_a_j = ~ro_a_j;
            #(41.5);
          end
        end
        begin
          step(12);
          pulse_start();
          step(S + W + 3);
        end
      join
      @(posedge clk);
      #1;
    end
    jit_mode = 1'b0;
    step(4);

    end_req = 1'b1;
    step(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
